// File: rtl/npu_layer_sequencer.sv
// Layer/neuron control FSM sitting directly upstream of reg_cntr_cmprtr.
// For each layer it fetches the header (inputs, neurons) from BRAM, strobes
// initialization, preloads the counters and then walks the neurons:
// LOAD until inner_cycle_match, ACT for ACT_LATENCY cycles, NEXT_N.
// All control outputs are registered: each one is decoded from the next state.
// Optional feature: define NPU_SEQ_ABORT_EN to add the abort_i input.
module npu_layer_sequencer #(
  parameter int unsigned NPU_DATA_WIDTH = 16,
  parameter int unsigned ACT_LATENCY    = 3,
  parameter int unsigned HDR_BASE_ADDR  = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_b_i,            // active-high async reset
`ifdef NPU_SEQ_ABORT_EN
  input  logic                      abort_i,
`endif
  input  logic                      start_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [NPU_DATA_WIDTH-1:0] num_layers_i,
  output logic [NPU_DATA_WIDTH-1:0] hdr_addr_o,
  output logic                      hdr_en_o,
  output logic                      initialization_o,
  output logic [1:0]                mode_o,
  output logic [1:0]                layer_postion_o,
  output logic [NPU_DATA_WIDTH-1:0] layer_number_o,
  output logic                      load_o,
  output logic                      first_preload_o,
  output logic                      inner_preload_o,
  output logic                      outter_clear_o,
  output logic                      activion_valid_o,
  input  logic                      inner_cycle_match_i,
  input  logic                      outer_cycle_match_i,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned DW   = NPU_DATA_WIDTH;
  localparam int unsigned CntW = (ACT_LATENCY > 1) ? $clog2(ACT_LATENCY) : 1;
  localparam logic [CntW-1:0] ActLast = CntW'(ACT_LATENCY - 1);

  typedef enum logic [3:0] {
    StIdle, StHdrRd, StHdrWait, StInit, StPreload, StLoad, StAct, StNextN, StNextL, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   layer_q, layer_d;
  logic [DW-1:0]   num_q, num_d;
  logic [1:0]      mode_q, mode_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   hdr_addr_q, hdr_addr_d;
  logic [1:0]      pos_q, pos_d;
  logic            hdr_en_q, hdr_en_d;
  logic            init_q, init_d;
  logic            load_q, load_d;
  logic            first_pre_q, first_pre_d;
  logic            inner_pre_q, inner_pre_d;
  logic            oclear_q, oclear_d;
  logic            act_q, act_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            abort_hit;

  // Next-state, latched configuration and registered-output decode
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    num_d      = num_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
`ifdef NPU_SEQ_ABORT_EN
    abort_hit  = abort_i && (state_q != StIdle);
`else
    abort_hit  = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = cfg_mode_i;
          num_d   = num_layers_i;
          layer_d = '0;
          state_d = (num_layers_i == '0) ? StDone : StHdrRd;
        end
      end
      StHdrRd:   state_d = StHdrWait;
      StHdrWait: state_d = StInit;
      StInit:    state_d = StPreload;
      StPreload: state_d = StLoad;
      StLoad: begin
        if (inner_cycle_match_i) begin
          state_d = StAct;
          cnt_d   = '0;
        end
      end
      StAct: begin
        if (cnt_q == ActLast) state_d = StNextN;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      // Outer match is sampled before the outer counter advances
      StNextN:   state_d = outer_cycle_match_i ? StNextL : StLoad;
      StNextL: begin
        layer_d = layer_q + 1'b1;
        state_d = (layer_d == num_q) ? StDone : StHdrRd;
      end
      StDone: begin
        state_d = StIdle;
        layer_d = '0;
      end
      default:   state_d = StIdle;
    endcase

    if (abort_hit) begin
      state_d = StIdle;
      layer_d = '0;
      cnt_d   = '0;
    end

    hdr_en_d    = (state_d == StHdrRd);
    hdr_addr_d  = (state_d == StHdrRd) ? DW'(HDR_BASE_ADDR) + layer_d : hdr_addr_q;
    init_d      = (state_d == StInit);
    load_d      = (state_d == StLoad);
    first_pre_d = (state_d == StPreload);
    // Preloading in NEXT_N on the last neuron is harmless: the next layer's
    // PRELOAD reloads the inner counter before it is used again.
    inner_pre_d = (state_d == StPreload) || (state_d == StNextN);
    oclear_d    = (state_d == StPreload) || abort_hit;
    act_d       = (state_d == StAct) && (cnt_d == ActLast);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);

    // Last layer wins over first so a single-layer network reports 11
    if ((state_d == StIdle) || (state_d == StDone)) pos_d = 2'b00;
    else if (layer_d == num_d - 1'b1)               pos_d = 2'b11;
    else if (layer_d == '0)                         pos_d = 2'b00;
    else                                            pos_d = 2'b10;
  end

  // State, configuration and output registers
  always_ff @(posedge clk_i or posedge reset_b_i) begin
    if (reset_b_i) begin
      state_q     <= StIdle;
      layer_q     <= '0;
      num_q       <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      hdr_addr_q  <= '0;
      pos_q       <= '0;
      hdr_en_q    <= 1'b0;
      init_q      <= 1'b0;
      load_q      <= 1'b0;
      first_pre_q <= 1'b0;
      inner_pre_q <= 1'b0;
      oclear_q    <= 1'b0;
      act_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      num_q       <= num_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      hdr_addr_q  <= hdr_addr_d;
      pos_q       <= pos_d;
      hdr_en_q    <= hdr_en_d;
      init_q      <= init_d;
      load_q      <= load_d;
      first_pre_q <= first_pre_d;
      inner_pre_q <= inner_pre_d;
      oclear_q    <= oclear_d;
      act_q       <= act_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign hdr_addr_o       = hdr_addr_q;
  assign hdr_en_o         = hdr_en_q;
  assign initialization_o = init_q;
  assign mode_o           = mode_q;
  assign layer_postion_o  = pos_q;
  assign layer_number_o   = layer_q;
  assign load_o           = load_q;
  assign first_preload_o  = first_pre_q;
  assign inner_preload_o  = inner_pre_q;
  assign outter_clear_o   = oclear_q;
  assign activion_valid_o = act_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Directed bench for npu_layer_sequencer (ACT_LATENCY = 3, HDR_BASE_ADDR = 0).
// The abort scenario is compiled in only when NPU_SEQ_ABORT_EN is defined.
module tb_npu_layer_sequencer;

  localparam int DW     = 16;
  localparam int ActLat = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    cfg_mode = 2'b00;
  logic [DW-1:0] num_layers = '0;
  logic          inner_m = 1'b0;
  logic          outer_m = 1'b0;
`ifdef NPU_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  logic [DW-1:0] hdr_addr, layer_number;
  logic [1:0]    mode, layer_pos;
  logic hdr_en, init, load, first_pre, inner_pre, oclear, act_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int n_init = 0, n_done = 0, n_hdr = 0, n_act = 0;
  int b_init, b_done, b_hdr, b_act;
  logic [1:0] pos_tab [3];

  npu_layer_sequencer #(
    .NPU_DATA_WIDTH(DW),
    .ACT_LATENCY   (ActLat),
    .HDR_BASE_ADDR (0)
  ) dut (
    .clk_i              (clk),
    .reset_b_i          (rst),
`ifdef NPU_SEQ_ABORT_EN
    .abort_i            (abort),
`endif
    .start_i            (start),
    .cfg_mode_i         (cfg_mode),
    .num_layers_i       (num_layers),
    .hdr_addr_o         (hdr_addr),
    .hdr_en_o           (hdr_en),
    .initialization_o   (init),
    .mode_o             (mode),
    .layer_postion_o    (layer_pos),
    .layer_number_o     (layer_number),
    .load_o             (load),
    .first_preload_o    (first_pre),
    .inner_preload_o    (inner_pre),
    .outter_clear_o     (oclear),
    .activion_valid_o   (act_valid),
    .inner_cycle_match_i(inner_m),
    .outer_cycle_match_i(outer_m),
    .busy_o             (busy),
    .done_o             (done)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (init)      n_init++;
    if (done)      n_done++;
    if (hdr_en)    n_hdr++;
    if (act_valid) n_act++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_init = n_init;
    b_done = n_done;
    b_hdr  = n_hdr;
    b_act  = n_act;
  endtask

  // Entry: state HDR_RD. Exit: first LOAD cycle.
  task automatic layer_hdr(input string tag, input int addr, input logic [1:0] pos);
    check({tag, "_hdr_en"}, hdr_en, 1);
    check({tag, "_hdr_addr"}, hdr_addr, addr);
    check({tag, "_layer_num"}, layer_number, addr);
    check({tag, "_pos"}, layer_pos, pos);
    tick();
    check({tag, "_wait_hdr_en"}, hdr_en, 0);
    check({tag, "_wait_init"}, init, 0);
    tick();
    check({tag, "_init"}, init, 1);
    tick();
    check({tag, "_init_pulse_end"}, init, 0);
    check({tag, "_first_pre"}, first_pre, 1);
    check({tag, "_inner_pre"}, inner_pre, 1);
    check({tag, "_oclear"}, oclear, 1);
    check({tag, "_pre_load"}, load, 0);
    tick();
  endtask

  // Entry: first LOAD cycle. Exit: LOAD (more neurons) or NEXT_L (last).
  task automatic neuron(input string tag, input int n_in, input bit last);
    for (int i = 1; i <= n_in; i++) begin
      check({tag, "_load"}, load, 1);
      check({tag, "_load_valid"}, act_valid, 0);
      if (i == n_in) begin
        inner_m = 1'b1;
        outer_m = last;
      end
      tick();
    end
    inner_m = 1'b0;
    for (int k = 1; k <= ActLat; k++) begin
      check({tag, "_act_load"}, load, 0);
      check({tag, "_act_valid"}, act_valid, (k == ActLat) ? 1 : 0);
      tick();
    end
    check({tag, "_nextn_valid"}, act_valid, 0);
    if (!last) check({tag, "_nextn_inner_pre"}, inner_pre, 1);
    tick();
    outer_m = 1'b0;
  endtask

  initial begin
    pos_tab[0] = 2'b00;
    pos_tab[1] = 2'b10;
    pos_tab[2] = 2'b11;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hdr_en", hdr_en, 0);
    check("rst_layer_num", layer_number, 0);
    check("rst_pos", layer_pos, 0);

    // T2: zero layers goes straight to DONE
    snap();
    num_layers = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_done", done, 1);
    check("t2_busy", busy, 1);
    tick();
    check("t2_done_end", done, 0);
    check("t2_busy_end", busy, 0);
    tick();
    check("t2_no_hdr", n_hdr - b_hdr, 0);
    check("t2_no_init", n_init - b_init, 0);
    check("t2_one_done", n_done - b_done, 1);

    // T3: one layer, 4 inputs, 2 neurons
    snap();
    num_layers = 16'd1;
    cfg_mode = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_mode", mode, 2'b10);
    check("t3_busy", busy, 1);
    layer_hdr("t3", 0, 2'b11);
    neuron("t3n0", 4, 1'b0);
    neuron("t3n1", 4, 1'b1);
    check("t3_nextl_done", done, 0);
    tick();
    check("t3_done", done, 1);
    tick();
    check("t3_done_end", done, 0);
    check("t3_idle_busy", busy, 0);
    check("t3_idle_layer", layer_number, 0);
    check("t3_act_pulses", n_act - b_act, 2);

    // T4: three layers, 2 inputs, 1 neuron each
    snap();
    num_layers = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      layer_hdr($sformatf("t4l%0d", k), k, pos_tab[k]);
      neuron($sformatf("t4l%0dn", k), 2, 1'b1);
      tick();
    end
    check("t4_done", done, 1);
    tick();
    check("t4_idle_busy", busy, 0);
    check("t4_init_pulses", n_init - b_init, 3);
    check("t4_hdr_reads", n_hdr - b_hdr, 3);
    check("t4_done_pulses", n_done - b_done, 1);

    // T5: start held high, cfg changes mid-run, 1-input layer
    snap();
    num_layers = 16'd1;
    cfg_mode = 2'b11;
    start = 1'b1;
    tick();
    cfg_mode = 2'b00;
    layer_hdr("t5", 0, 2'b11);
    neuron("t5n", 1, 1'b1);
    check("t5_mode_held", mode, 2'b11);
    tick();
    check("t5_done", done, 1);
    start = 1'b0;
    tick();
    tick();
    check("t5_idle_busy", busy, 0);
    check("t5_one_done", n_done - b_done, 1);
    check("t5_one_hdr", n_hdr - b_hdr, 1);

`ifdef NPU_SEQ_ABORT_EN
    // T6: abort during ACT
    snap();
    num_layers = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    layer_hdr("t6", 0, 2'b11);
    inner_m = 1'b1;
    tick();
    inner_m = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_oclear", oclear, 1);
    check("t6_valid", act_valid, 0);
    check("t6_done", done, 0);
    tick();
    check("t6_oclear_end", oclear, 0);
    check("t6_no_done", n_done - b_done, 0);
    check("t6_no_act", n_act - b_act, 0);
`endif

    // T1: asynchronous reset mid-LOAD
    num_layers = 16'd2;
    cfg_mode = 2'b01;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t1_in_load", load, 1);
    rst = 1'b1;
    #1;
    check("t1_load", load, 0);
    check("t1_busy", busy, 0);
    check("t1_mode", mode, 0);
    check("t1_pos", layer_pos, 0);
    check("t1_inner_pre", inner_pre, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t1_after_busy", busy, 0);
    check("t1_after_load", load, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
